lcd_ctrl: RTL and testbench

Parametrised HD44780-style character-LCD write controller for the Qsys-based display subsystem. It buffers `{rs, byte}` write commands from the bus side in a FIFO and replays them onto the LCD pins (`data`, `rs`, `rw`, `en`) with programmable setup, enable-width, hold and execution-wait timing counted in clock cycles. It supports 8-bit and 4-bit (two-nibble) bus modes and a power-up wait. It replaces the fixed 8-bit, software-timed LCD output ports and drives the same top-level LCD pins.

---
 rtl/lcd_ctrl_pkg.sv | 43 ++++
 rtl/lcd_ctrl_fifo.sv | 79 +++++++
 rtl/lcd_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// lcd_ctrl_pkg
// Shared types and helpers for the HD44780-style LCD write controller.
//   lcd_state_e   : controller FSM state encoding
//   lcd_cmd_t     : one queued write, {rs, data[7:0]}
//   is_long_cmd() : true for clear/home instructions, which need the long
//                   execution wait
//   max_int()     : elaboration-time helper for sizing the timing counter
// ----------------------------------------------------------------------------
package lcd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_POWERUP = 3'd0,
        ST_IDLE    = 3'd1,
        ST_SETUP   = 3'd2,
        ST_EN_HI   = 3'd3,
        ST_HOLD    = 3'd4,
        ST_EXEC    = 3'd5
    } lcd_state_e;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_cmd_t;

    localparam int LCD_CMD_W = $bits(lcd_cmd_t);

    // Clear is 0x01; home decodes as 0x02 or 0x03 (bit 0 is don't-care).
    // Data writes and the null instruction 0x00 are short.
    function automatic logic is_long_cmd(input lcd_cmd_t cmd);
        logic hit;
        hit = (cmd.data == CMD_CLEAR) || ({cmd.data[7:1], 1'b0} == CMD_HOME);
        return !cmd.rs && hit;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_ctrl_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO used to queue LCD write commands. Show-ahead read:
// rd_data always presents the head entry while the FIFO is non-empty.
// Push when full and pop when empty are ignored.
// Ports:
//   clk, rst_n      : clock, async active-low reset (flushes the FIFO)
//   push, wr_data   : write request and data
//   pop             : remove head entry
//   rd_data         : head entry
//   full, empty     : status flags from the registered level
//   level           : number of stored entries, 0..DEPTH
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem[rd_ptr_q];

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/lcd_ctrl.sv
// ----------------------------------------------------------------------------
// lcd_ctrl
// HD44780-style character-LCD write controller. Bus-side {rs, byte} writes
// are queued in a FIFO and replayed onto the LCD pins with cycle-counted
// setup / enable / hold / execution timing. BUS_W=4 sends each byte as two
// nibbles, high first, with no execution wait between them.
// Ports:
//   clk_clk, reset_reset_n : clock, async active-low reset
//   cmd_valid/ready        : command handshake (ready = FIFO not full)
//   cmd_rs, cmd_data       : register select and byte of the command
//   lcd_data, lcd_rs       : LCD pins, change only when entering SETUP
//   lcd_rw                 : tied low, write-only
//   lcd_en                 : enable strobe
//   busy                   : not IDLE or commands pending
//   fifo_level             : commands queued
//
// state    | meaning
// ---------+-------------------------------------------------------------
// POWERUP  | wait T_POWERUP cycles after reset, pushes still accepted
// IDLE     | pop head when FIFO non-empty, load rs and first beat
// SETUP    | rs/data settling for T_SETUP cycles, en low
// EN_HI    | en high for T_EN cycles
// HOLD     | en low, rs/data held T_HOLD cycles; 4-bit first nibble
//          | goes back to SETUP with the low nibble
// EXEC     | wait T_EXEC or T_EXEC_LONG for the LCD to execute
// ----------------------------------------------------------------------------
module lcd_ctrl
    import lcd_ctrl_pkg::*;
#(
    parameter int BUS_W       = 8,
    parameter int DEPTH       = 16,
    parameter int T_POWERUP   = 750000,
    parameter int T_SETUP     = 4,
    parameter int T_EN        = 12,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 76000
) (
    input  logic                         clk_clk,
    input  logic                         reset_reset_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_rs,
    input  logic [7:0]                   cmd_data,
    output logic [BUS_W-1:0]             lcd_data,
    output logic                         lcd_rs,
    output logic                         lcd_rw,
    output logic                         lcd_en,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

    localparam int T_MAX = max_int(max_int(max_int(T_POWERUP, T_SETUP),
                                           max_int(T_EN, T_HOLD)),
                                   max_int(T_EXEC, T_EXEC_LONG));
    localparam int CNT_W = $clog2(T_MAX + 1);

    // The counter is loaded with T-1 on state entry and the state is left
    // when it reads zero, so each state lasts exactly T cycles.
    localparam logic [CNT_W-1:0] CNT_POWERUP   = CNT_W'(T_POWERUP - 1);
    localparam logic [CNT_W-1:0] CNT_SETUP     = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] CNT_EN        = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] CNT_HOLD      = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_EXEC      = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] CNT_EXEC_LONG = CNT_W'(T_EXEC_LONG - 1);

    lcd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    lcd_cmd_t         cmd_q, cmd_d;
    logic             second_q, second_d;
    logic [BUS_W-1:0] lcd_data_q, lcd_data_d;
    logic             lcd_rs_q, lcd_rs_d;
    logic             lcd_en_q, lcd_en_d;

    lcd_cmd_t         push_cmd;
    lcd_cmd_t         head_cmd;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [BUS_W-1:0] beat_first;
    logic [BUS_W-1:0] beat_second;

    assign push_cmd = '{rs: cmd_rs, data: cmd_data};

    sync_fifo #(
        .WIDTH (LCD_CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .push    (cmd_valid),
        .wr_data (push_cmd),
        .pop     (fifo_pop),
        .rd_data (head_cmd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // First beat comes straight from the FIFO head (loaded on pop); the
    // second nibble comes from the captured command.
    if (BUS_W == 4) begin : g_nibble
        assign beat_first  = head_cmd.data[7:4];
        assign beat_second = cmd_q.data[3:0];
    end else begin : g_byte
        assign beat_first  = head_cmd.data;
        assign beat_second = cmd_q.data;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        second_d   = second_q;
        lcd_data_d = lcd_data_q;
        lcd_rs_d   = lcd_rs_q;
        lcd_en_d   = lcd_en_q;
        fifo_pop   = 1'b0;

        case (state_q)
            ST_POWERUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    cmd_d      = head_cmd;
                    lcd_rs_d   = head_cmd.rs;
                    lcd_data_d = beat_first;
                    second_d   = 1'b0;
                    state_d    = ST_SETUP;
                    cnt_d      = CNT_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d  = ST_EN_HI;
                    lcd_en_d = 1'b1;
                    cnt_d    = CNT_EN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_EN_HI: begin
                if (cnt_q == '0) begin
                    state_d  = ST_HOLD;
                    lcd_en_d = 1'b0;
                    cnt_d    = CNT_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    if ((BUS_W == 4) && !second_q) begin
                        second_d   = 1'b1;
                        lcd_data_d = beat_second;
                        state_d    = ST_SETUP;
                        cnt_d      = CNT_SETUP;
                    end else begin
                        state_d = ST_EXEC;
                        cnt_d   = is_long_cmd(cmd_q) ? CNT_EXEC_LONG : CNT_EXEC;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d  = ST_POWERUP;
                cnt_d    = CNT_POWERUP;
                lcd_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q    <= ST_POWERUP;
            cnt_q      <= CNT_POWERUP;
            cmd_q      <= '0;
            second_q   <= 1'b0;
            lcd_data_q <= '0;
            lcd_rs_q   <= 1'b0;
            lcd_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            second_q   <= second_d;
            lcd_data_q <= lcd_data_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_en_q   <= lcd_en_d;
        end
    end

    assign lcd_data  = lcd_data_q;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_en    = lcd_en_q;
    assign cmd_ready = !fifo_full;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_lcd_ctrl.sv
module tb_lcd_ctrl;

    localparam int DEPTH       = 4;
    localparam int T_POWERUP   = 20;
    localparam int T_SETUP     = 2;
    localparam int T_EN        = 4;
    localparam int T_HOLD      = 2;
    localparam int T_EXEC      = 10;
    localparam int T_EXEC_LONG = 50;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 8-bit instance
    logic       c8_valid, c8_rs, c8_ready;
    logic [7:0] c8_data;
    logic [7:0] d8;
    logic       rs8, rw8, en8, busy8;
    logic [2:0] lvl8;

    // 4-bit instance
    logic       c4_valid, c4_rs, c4_ready;
    logic [7:0] c4_data;
    logic [3:0] d4;
    logic       rs4, rw4, en4, busy4;
    logic [2:0] lvl4;

    lcd_ctrl #(
        .BUS_W(8), .DEPTH(DEPTH), .T_POWERUP(T_POWERUP), .T_SETUP(T_SETUP),
        .T_EN(T_EN), .T_HOLD(T_HOLD), .T_EXEC(T_EXEC), .T_EXEC_LONG(T_EXEC_LONG)
    ) dut8 (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .cmd_valid(c8_valid), .cmd_ready(c8_ready), .cmd_rs(c8_rs), .cmd_data(c8_data),
        .lcd_data(d8), .lcd_rs(rs8), .lcd_rw(rw8), .lcd_en(en8),
        .busy(busy8), .fifo_level(lvl8)
    );

    lcd_ctrl #(
        .BUS_W(4), .DEPTH(DEPTH), .T_POWERUP(T_POWERUP), .T_SETUP(T_SETUP),
        .T_EN(T_EN), .T_HOLD(T_HOLD), .T_EXEC(T_EXEC), .T_EXEC_LONG(T_EXEC_LONG)
    ) dut4 (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .cmd_valid(c4_valid), .cmd_ready(c4_ready), .cmd_rs(c4_rs), .cmd_data(c4_data),
        .lcd_data(d4), .lcd_rs(rs4), .lcd_rw(rw4), .lcd_en(en4),
        .busy(busy4), .fifo_level(lvl4)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // EN pulse monitors: rise cycle, data/rs at rise, pulse width
    int rc8[$], rd8[$], rr8[$], w8[$];
    int rc4[$], rd4[$], rr4[$], w4[$];
    int last8 = 0, last4 = 0;
    logic p8 = 1'b0, p4 = 1'b0;

    always @(negedge clk) begin
        if (en8 && !p8) begin
            rc8.push_back(cyc); rd8.push_back(int'(d8)); rr8.push_back(int'(rs8));
            last8 = cyc;
        end
        if (!en8 && p8) w8.push_back(cyc - last8);
        p8 <= en8;
        if (en4 && !p4) begin
            rc4.push_back(cyc); rd4.push_back(int'(d4)); rr4.push_back(int'(rs4));
            last4 = cyc;
        end
        if (!en4 && p4) w4.push_back(cyc - last4);
        p4 <= en4;
    end

    task automatic clear_mon();
        rc8.delete(); rd8.delete(); rr8.delete(); w8.delete();
        rc4.delete(); rd4.delete(); rr4.delete(); w4.delete();
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input bit sel4, input logic rs, input logic [7:0] d, output int acc_edge);
        int n = 0;
        if (sel4) begin c4_valid = 1'b1; c4_rs = rs; c4_data = d; end
        else      begin c8_valid = 1'b1; c8_rs = rs; c8_data = d; end
        while (!(sel4 ? c4_ready : c8_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk_eq("push_ready_timeout", int'(sel4 ? c4_ready : c8_ready), 1);
        acc_edge = cyc + 1;
        @(negedge clk);
        if (sel4) c4_valid = 1'b0; else c8_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit sel4, output int fall);
        int n = 0;
        while ((sel4 ? busy4 : busy8) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk_eq("idle_timeout", int'(sel4 ? busy4 : busy8), 0);
        fall = cyc;
    endtask

    // {rs, byte, busy-fall offset from accept edge}
    typedef struct { logic rs; logic [7:0] b; int ofs; } exec_vec_t;
    exec_vec_t ev[7];

    typedef struct { logic rs; logic [7:0] b; int hi; int lo; int ofs; } nib_vec_t;
    nib_vec_t nv[2];

    initial begin
        int r, acc, acc2, fall, n;

        // short: 1+2+4+2+10 = 19, long: 1+2+4+2+50 = 59
        ev[0] = '{1'b0, 8'h01, 59};
        ev[1] = '{1'b0, 8'h00, 19};
        ev[2] = '{1'b0, 8'h03, 59};
        ev[3] = '{1'b0, 8'h04, 19};
        ev[4] = '{1'b1, 8'h02, 19};
        ev[5] = '{1'b0, 8'h02, 59};
        ev[6] = '{1'b1, 8'h01, 19};
        // 4-bit: 1+8+8+exec
        nv[0] = '{1'b1, 8'hA5, 4'hA, 4'h5, 27};
        nv[1] = '{1'b0, 8'h01, 4'h0, 4'h1, 67};

        rst_n = 1'b0;
        c8_valid = 1'b0; c8_rs = 1'b0; c8_data = 8'h00;
        c4_valid = 1'b0; c4_rs = 1'b0; c4_data = 8'h00;
        repeat (3) @(negedge clk);

        // reset values
        chk_eq("rst_en", en8, 0);
        chk_eq("rst_data", d8, 0);
        chk_eq("rst_rs", rs8, 0);
        chk_eq("rst_rw", rw8, 0);
        chk_eq("rst_busy", busy8, 1);
        chk_eq("rst_level", lvl8, 0);
        chk_eq("rst_ready", c8_ready, 1);
        chk_eq("rst_data4", d4, 0);

        // power-up: push 0x41 on the first edge after release
        clear_mon();
        r = cyc;
        rst_n = 1'b1;
        push(1'b0, 1'b1, 8'h41, acc);
        chk_eq("pu_accept", acc, r + 1);
        chk_eq("pu_level", lvl8, 1);
        chk_eq("pu_busy", busy8, 1);
        wait_idle(1'b0, fall);
        chk_eq("pu_pulses", rc8.size(), 1);
        if (rc8.size() > 0) begin
            chk_eq("pu_rise", rc8[0], r + T_POWERUP + 1 + T_SETUP);
            chk_eq("pu_data", rd8[0], 8'h41);
            chk_eq("pu_rs", rr8[0], 1);
        end
        if (w8.size() > 0) chk_eq("pu_width", w8[0], T_EN);
        chk_eq("pu_busy_fall", fall, r + 39);

        // 4-bit mode
        for (int i = 0; i < 2; i++) begin
            clear_mon();
            push(1'b1, nv[i].rs, nv[i].b, acc);
            wait_idle(1'b1, fall);
            chk_eq("nib_pulses", rc4.size(), 2);
            if (rc4.size() >= 2) begin
                chk_eq("nib_rise0", rc4[0], acc + 3);
                chk_eq("nib_gap", rc4[1] - rc4[0], 8);
                chk_eq("nib_hi", rd4[0], nv[i].hi);
                chk_eq("nib_lo", rd4[1], nv[i].lo);
                chk_eq("nib_rs0", rr4[0], int'(nv[i].rs));
                chk_eq("nib_rs1", rr4[1], int'(nv[i].rs));
            end
            if (w4.size() >= 2) chk_eq("nib_width1", w4[1], T_EN);
            chk_eq("nib_busy_fall", fall, acc + nv[i].ofs);
        end

        // back-to-back 0x38, 0x0C
        clear_mon();
        push(1'b0, 1'b0, 8'h38, acc);
        push(1'b0, 1'b0, 8'h0C, acc2);
        chk_eq("b2b_accept2", acc2, acc + 1);
        wait_idle(1'b0, fall);
        chk_eq("b2b_pulses", rc8.size(), 2);
        if (rc8.size() >= 2) begin
            chk_eq("b2b_rise0", rc8[0], acc + 3);
            chk_eq("b2b_gap", rc8[1] - rc8[0], 19);
            chk_eq("b2b_data0", rd8[0], 8'h38);
            chk_eq("b2b_data1", rd8[1], 8'h0C);
            chk_eq("b2b_rs1", rr8[1], 0);
        end
        chk_eq("b2b_busy_fall", fall, acc + 38);

        // long vs short execution wait
        for (int i = 0; i < 7; i++) begin
            clear_mon();
            push(1'b0, ev[i].rs, ev[i].b, acc);
            wait_idle(1'b0, fall);
            chk_eq("exec_busy_fall", fall, acc + ev[i].ofs);
            if (rc8.size() > 0) chk_eq("exec_data", rd8[0], int'(ev[i].b));
        end

        // backpressure: 5 pushes during POWERUP
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clear_mon();
        r = cyc;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) push(1'b0, 1'b1, 8'(8'h11 * (i + 1)), acc);
        chk_eq("bp_ready_full", c8_ready, 0);
        chk_eq("bp_level_full", lvl8, 4);
        push(1'b0, 1'b1, 8'h55, acc);
        chk_eq("bp_accept5", acc, r + T_POWERUP + 2);
        chk_eq("bp_level_after", lvl8, 4);
        wait_idle(1'b0, fall);
        chk_eq("bp_pulses", rc8.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < rc8.size()) chk_eq("bp_order", rd8[i], 8'h11 * (i + 1));

        // reset mid-transfer
        push(1'b0, 1'b1, 8'h55, acc);
        push(1'b0, 1'b1, 8'h66, acc2);
        n = 0;
        while (!en8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk_eq("mid_en_seen", en8, 1);
        chk_eq("mid_rw", rw8, 0);
        chk_eq("mid_level", lvl8, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("mid_rst_en", en8, 0);
        chk_eq("mid_rst_level", lvl8, 0);
        chk_eq("mid_rst_ready", c8_ready, 1);
        chk_eq("mid_rst_busy", busy8, 1);
        chk_eq("mid_rst_data", d8, 0);
        chk_eq("mid_rst_rs", rs8, 0);
        @(negedge clk);
        @(negedge clk);
        clear_mon();
        r = cyc;
        rst_n = 1'b1;
        push(1'b0, 1'b1, 8'h77, acc);
        wait_idle(1'b0, fall);
        chk_eq("re_pulses", rc8.size(), 1);
        if (rc8.size() > 0) begin
            chk_eq("re_rise", rc8[0], r + T_POWERUP + 1 + T_SETUP);
            chk_eq("re_data", rd8[0], 8'h77);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
